glb_pe_feeder: RTL and testbench

- Global-buffer-side transmitter for the PE load interface (weights or ifmap).
- Streams a programmed address range out of a synchronous-read GLB SRAM onto the PE bus.
- Paced by the PE's load-ready signal.
- Drives the start-load pulse, full-column flag and bus ID ahead of the burst; one instance per data class (weight, feature).

---
 rtl/glb_pe_feeder.sv | 189 ++++++++++++++++++
 tb/tb_glb_pe_feeder.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/glb_pe_feeder.sv
// glb_pe_feeder
//   Global-buffer-side transmitter for the PE load interface. One instance is
//   used per data class (weights or ifmap). On a start request it latches an
//   address range, pulses pe_start_load, and then streams GLB SRAM words from
//   start_addr up to (but excluding) end_addr onto the PE bus. The range wraps
//   modulo 2^ADDR_WIDTH. The stream is paced by pe_load_ready.
//
//   Optional build macro: GLB_FEEDER_SKID_EN
//     undefined : bus_valid is the read enable delayed by one cycle. A read
//                 already issued when ready falls is still delivered, giving a
//                 one-beat overshoot that the PE tolerates.
//     defined   : strict ready/valid. Returning SRAM words land in a 2-entry
//                 skid FIFO, and the bus is driven from the FIFO head.
//
//   Ports
//     clk, rst_n           clock, asynchronous active-low reset
//     start                one-cycle burst request (honoured only in IDLE)
//     start_addr/end_addr  burst range [start_addr, end_addr)
//     target_id            bus ID presented for the whole burst
//     full_column          value driven on pe_load_full_column
//     pe_load_ready        PE can accept data
//     glb_rd_en/addr/data  synchronous-read SRAM port (data one cycle after en)
//     pe_start_load        one-cycle pulse ahead of the burst
//     pe_load_full_column  latched full_column, held while busy
//     bus_id/data/valid    PE bus
//     busy                 high from START through DONE
//     done                 one-cycle completion pulse
//     beat_cnt             beats delivered in the current or last burst
module glb_pe_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 7,
  parameter int ID_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [ADDR_WIDTH-1:0] end_addr,
  input  logic [ID_WIDTH-1:0]   target_id,
  input  logic                  full_column,
  input  logic                  pe_load_ready,
  input  logic [DATA_WIDTH-1:0] glb_rd_data,
  output logic                  glb_rd_en,
  output logic [ADDR_WIDTH-1:0] glb_rd_addr,
  output logic                  pe_start_load,
  output logic                  pe_load_full_column,
  output logic [ID_WIDTH-1:0]   bus_id,
  output logic [DATA_WIDTH-1:0] bus_data,
  output logic                  bus_valid,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH:0]   beat_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH-1:0] end_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic                  fc_q;
  logic [ADDR_WIDTH:0]   cnt_q;

  logic                  more;       // addresses left in the range
  logic                  rd_go;      // read issued this cycle
  logic                  rd_vld_p1;  // read issued last cycle; SRAM data valid now
  logic                  beat;       // a beat is on the bus this cycle
  logic                  drain_ok;   // nothing left in flight or buffered

  assign more = (addr_q != end_q);

`ifdef GLB_FEEDER_SKID_EN
  logic [DATA_WIDTH-1:0] skid_mem [2];
  logic                  wr_ptr_q, rd_ptr_q;
  logic [1:0]            occ_q;
  logic [1:0]            pend;
  logic                  push, pop;

  // Occupancy plus in-flight read bounded to 2, so a push never finds the FIFO full.
  assign pend     = occ_q + {1'b0, rd_vld_p1};
  assign rd_go    = (state_q == S_STREAM) && more && (pend < 2'd2);
  assign push     = rd_vld_p1;
  assign pop      = (occ_q != 2'd0) && pe_load_ready;
  assign beat     = pop;
  assign drain_ok = !rd_vld_p1 && (occ_q == 2'd0);
  assign bus_data = pop ? skid_mem[rd_ptr_q] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      occ_q    <= 2'd0;
    end else begin
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   occ_q <= occ_q + 2'd1;
        2'b01:   occ_q <= occ_q - 2'd1;
        default: occ_q <= occ_q;
      endcase
    end
  end

  // FIFO storage is data only; the pointers and occupancy qualify it.
  always_ff @(posedge clk) begin
    if (push) skid_mem[wr_ptr_q] <= glb_rd_data;
  end
`else
  assign rd_go    = (state_q == S_STREAM) && more && pe_load_ready;
  assign beat     = rd_vld_p1;
  assign drain_ok = !rd_vld_p1;
  assign bus_data = rd_vld_p1 ? glb_rd_data : '0;
`endif

  // ---- p0 -> p1: read issue to SRAM data return ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rd_vld_p1 <= 1'b0;
    else        rd_vld_p1 <= rd_go;
  end

  // State register and burst context
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      end_q   <= '0;
      id_q    <= '0;
      fc_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && start) begin
        addr_q <= start_addr;
        end_q  <= end_addr;
        id_q   <= target_id;
        fc_q   <= full_column;
      end else if (rd_go) begin
        addr_q <= addr_q + 1'b1;
      end
      if (state_q == S_START) cnt_q <= '0;
      else if (beat)          cnt_q <= cnt_q + 1'b1;
    end
  end

  // Next state and state-decoded outputs
  always_comb begin
    state_d             = state_q;
    pe_start_load       = 1'b0;
    busy                = 1'b1;
    done                = 1'b0;
    bus_id              = id_q;
    pe_load_full_column = fc_q;
    case (state_q)
      S_IDLE: begin
        busy                = 1'b0;
        bus_id              = '0;
        pe_load_full_column = 1'b0;
        if (start) state_d = S_START;
      end
      S_START: begin
        pe_start_load = 1'b1;
        state_d       = S_STREAM;
      end
      S_STREAM: begin
        if (!more) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (drain_ok) state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign glb_rd_en   = rd_go;
  assign glb_rd_addr = addr_q;
  assign bus_valid   = beat;
  assign beat_cnt    = cnt_q;

endmodule

// File: tb/tb_glb_pe_feeder.sv
// Directed bench for glb_pe_feeder: a table of bursts driven through one
// burst task, plus hand-written reset sequences. The SRAM model holds a+1 at
// address a, so every expected beat is ((start_addr+i) mod 128) + 1.
module tb_glb_pe_feeder;

  localparam int DW = 16;
  localparam int AW = 7;
  localparam int IW = 8;

`ifdef GLB_FEEDER_SKID_EN
  localparam int OVS_DROP = 0;
`else
  localparam int OVS_DROP = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW-1:0] start_addr, end_addr;
  logic [IW-1:0] target_id;
  logic          full_column;
  logic          pe_load_ready;
  logic [DW-1:0] glb_rd_data = '0;
  logic          glb_rd_en;
  logic [AW-1:0] glb_rd_addr;
  logic          pe_start_load, pe_load_full_column;
  logic [IW-1:0] bus_id;
  logic [DW-1:0] bus_data;
  logic          bus_valid, busy, done;
  logic [AW:0]   beat_cnt;

  logic [DW-1:0] mem [128];

  int checks = 0;
  int errors = 0;

  glb_pe_feeder #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr),
    .end_addr(end_addr), .target_id(target_id), .full_column(full_column),
    .pe_load_ready(pe_load_ready), .glb_rd_data(glb_rd_data),
    .glb_rd_en(glb_rd_en), .glb_rd_addr(glb_rd_addr),
    .pe_start_load(pe_start_load), .pe_load_full_column(pe_load_full_column),
    .bus_id(bus_id), .bus_data(bus_data), .bus_valid(bus_valid),
    .busy(busy), .done(done), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  // Synchronous-read SRAM
  always @(posedge clk) begin
    if (glb_rd_en) glb_rd_data <= mem[glb_rd_addr];
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_all_zero(input string name);
    logic [63:0] v;
    v = {19'd0, glb_rd_en, glb_rd_addr, pe_start_load, pe_load_full_column,
         bus_id, bus_data, bus_valid, busy, done, beat_cnt};
    check(name, v, 64'd0);
  endtask

  // Runs one burst. Ready is low for STREAM cycles lo..hi (0-based).
  // mid_cyc > 0 raises a second start with different arguments on that cycle.
  task automatic run_burst(input string tag, input int sa, input int ea,
                           input int id, input int fc, input int lo, input int hi,
                           input int mid_cyc, input int exp_cnt, input int exp_ovs,
                           input int exp_first);
    int beats[$];
    int addrs[$];
    int sl_cyc = -1, sl_pulses = 0, ovs = 0, id_bad = 0;
    int last_beat = -1, done_cyc = -1, bad_d = 0, bad_a = 0, k;
    logic seen = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; start_addr = AW'(sa); end_addr = AW'(ea);
    target_id = IW'(id); full_column = fc[0]; pe_load_ready = 1'b1;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      if (pe_start_load) begin sl_pulses++; sl_cyc = cyc; end
      if (bus_valid) begin
        beats.push_back(int'(bus_data));
        last_beat = cyc;
        if (!pe_load_ready) ovs++;
      end
      if (glb_rd_en) addrs.push_back(int'(glb_rd_addr));
      if (busy && (bus_id !== IW'(id) || pe_load_full_column !== fc[0])) id_bad++;
      if (done) begin seen = 1'b1; done_cyc = cyc; break; end
      @(posedge clk); #1;
      start = (cyc + 1 == mid_cyc);
      if (cyc + 1 == mid_cyc) begin
        start_addr = 7'd50; end_addr = 7'd60; target_id = ~IW'(id); full_column = ~fc[0];
      end
      k = cyc + 1 - 2;
      pe_load_ready = !(k >= lo && k <= hi);
    end
    check({tag, " done_seen"}, seen, 1);
    check({tag, " beat_cnt_at_done"}, beat_cnt, exp_cnt);
    check({tag, " start_load_cycle"}, sl_cyc, 1);
    check({tag, " start_load_pulses"}, sl_pulses, 1);
    check({tag, " beats"}, beats.size(), exp_cnt);
    check({tag, " reads"}, addrs.size(), exp_cnt);
    check({tag, " overshoot"}, ovs, exp_ovs);
    check({tag, " id_fc_stable"}, id_bad, 0);
    if (exp_cnt > 0) begin
      check({tag, " first_beat"}, beats.size() > 0 ? beats[0] : -1, exp_first);
      foreach (beats[i]) if (beats[i] != ((sa + i) % 128) + 1) bad_d++;
      foreach (addrs[i]) if (addrs[i] != (sa + i) % 128) bad_a++;
      check({tag, " data_seq_bad"}, bad_d, 0);
      check({tag, " addr_seq_bad"}, bad_a, 0);
      check({tag, " done_after_last_beat"},
            (done_cyc - last_beat >= 1) && (done_cyc - last_beat <= 2), 1);
    end
    @(posedge clk); #1;
    start = 1'b0; pe_load_ready = 1'b1;
    @(negedge clk);
    check({tag, " idle_busy"}, busy, 0);
    check({tag, " idle_bus_id"}, bus_id, 0);
    check({tag, " beat_cnt_hold"}, beat_cnt, exp_cnt);
  endtask

  typedef struct {
    string tag;
    int sa, ea, id, fc, lo, hi, mid, cnt, ovs, first;
  } vec_t;

  vec_t tbl[5];

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = DW'(i + 1);
    tbl[0] = '{"basic",    0,  8, 'h11, 1, 99, -1,  0,  8, 0,        1};
    tbl[1] = '{"ready_gap",8, 12, 'h22, 0,  1,  3,  0,  4, OVS_DROP, 9};
    tbl[2] = '{"empty",    5,  5, 'h05, 1, 99, -1,  0,  0, 0,        0};
    tbl[3] = '{"wrap",   126,  2, 'h7e, 0, 99, -1,  0,  4, 0,      127};
    tbl[4] = '{"mid_start",0, 36, 'hA5, 1, 99, -1, 10, 36, 0,        1};

    rst_n = 1'b0; start = 1'b0; start_addr = '0; end_addr = '0;
    target_id = '0; full_column = 1'b0; pe_load_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_outputs");
    @(negedge clk); rst_n = 1'b1;

    foreach (tbl[i])
      run_burst(tbl[i].tag, tbl[i].sa, tbl[i].ea, tbl[i].id, tbl[i].fc,
                tbl[i].lo, tbl[i].hi, tbl[i].mid, tbl[i].cnt, tbl[i].ovs, tbl[i].first);

    // Reset in the middle of a stream, then a clean burst afterwards.
    @(posedge clk); #1;
    start = 1'b1; start_addr = 7'd0; end_addr = 7'd16; target_id = 8'h33; full_column = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("mid_reset_was_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("mid_reset_outputs");
    @(negedge clk); rst_n = 1'b1;
    run_burst("after_reset", 20, 24, 'h44, 0, 99, -1, 0, 4, 0, 21);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
